// File: rtl/udp_rx_axis_pkt_checker.sv
`default_nettype none
// ============================================================================
//  Module   : udp_rx_axis_pkt_checker
//  Purpose  : Sink and checker for the UDP RX AXI-Stream. Verifies payload
//             pattern, sequence number and length of each packet. Keeps
//             packet, error and beat counters plus a fixed-length perf window.
//  Options  : RX_CHECKER_BP_EN - adds bp_rate input and LFSR-driven random
//             backpressure on s_axis_tready.
//  Revision : 1.0 - initial release
// ============================================================================
module udp_rx_axis_pkt_checker #(
    parameter int DATA_WIDTH  = 512,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int CNT_WIDTH   = 32,
    parameter int PERF_WINDOW = 1000000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    input  logic                  recv_enable,
    input  logic                  clear,
    input  logic [15:0]           pkt_size,
`ifdef RX_CHECKER_BP_EN
    input  logic [7:0]            bp_rate,
`endif
    output logic                  is_recv_first_pkt,
    output logic [CNT_WIDTH-1:0]  recv_pkt_num,
    output logic [CNT_WIDTH-1:0]  err_pkt_num,
    output logic [CNT_WIDTH-1:0]  total_beat_count,
    output logic [CNT_WIDTH-1:0]  perf_cycle_count,
    output logic [CNT_WIDTH-1:0]  perf_beat_count,
    output logic                  perf_cycle_count_full
);

    localparam int                   NUM_LANES = DATA_WIDTH / 32;
    localparam logic [CNT_WIDTH-1:0] PERF_LAST = CNT_WIDTH'(PERF_WINDOW - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_RUN        = 2'd2
    } state_t;

    state_t                 state_q;
    logic [15:0]            exp_len_q;
    logic [15:0]            exp_seq_q;
    logic [15:0]            pkt_seq_q;
    logic [15:0]            beat_idx_q;
    logic                   pkt_err_q;
    logic                   first_q;
    logic [CNT_WIDTH-1:0]   recv_q, err_q, total_q;
    logic [CNT_WIDTH-1:0]   perf_cycle_q, perf_beat_q;
    logic                   perf_run_q, perf_full_q;

    logic                   w_bp_stall;
    logic                   w_acc;
    logic [15:0]            w_seq;
    logic [15:0]            w_seq_cmp;
    logic [31:0]            w_exp_word;
    logic [NUM_LANES-1:0]   w_lane_err;
    logic [16:0]            w_exp_beats;
    logic [16:0]            w_beat_cnt;
    logic [15:0]            w_len_rem;
    logic [KEEP_WIDTH-1:0]  w_last_keep;
    logic                   w_beat_err;
    logic                   w_pkt_err;
    logic                   in_pkt_d;
    logic [CNT_WIDTH-1:0]   w_perf_cycle_inc;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef RX_CHECKER_BP_EN
    logic [15:0] lfsr_q;

    // Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11+1) for random stalls
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) lfsr_q <= 16'hACE1;
        else        lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    assign w_bp_stall = (lfsr_q[7:0] < bp_rate);
`else
    assign w_bp_stall = 1'b0;
`endif

    // Ready depends on state (and optional stall) only, never on tvalid
    assign s_axis_tready = (state_q != ST_IDLE) && !w_bp_stall;
    assign w_acc         = s_axis_tvalid && s_axis_tready;

    // Sequence number lives in lane0[31:16] of beat 0; held for later beats
    assign w_seq      = (beat_idx_q == 16'd0) ? s_axis_tdata[31:16] : pkt_seq_q;
    // The very first packet after enable defines the sequence, so never mismatches
    assign w_seq_cmp  = (state_q == ST_WAIT_FIRST) ? w_seq : exp_seq_q;
    assign w_exp_word = {w_seq, beat_idx_q};

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [31:0] w_byte_mask;
            assign w_byte_mask = {{8{s_axis_tkeep[gi*4+3]}}, {8{s_axis_tkeep[gi*4+2]}},
                                  {8{s_axis_tkeep[gi*4+1]}}, {8{s_axis_tkeep[gi*4+0]}}};
            assign w_lane_err[gi] = |((s_axis_tdata[gi*32 +: 32] ^ w_exp_word) & w_byte_mask);
        end
    endgenerate

    assign w_exp_beats = ({1'b0, exp_len_q} + 17'(KEEP_WIDTH - 1)) / 17'(KEEP_WIDTH);
    assign w_beat_cnt  = {1'b0, beat_idx_q} + 17'd1;
    assign w_len_rem   = exp_len_q % 16'(KEEP_WIDTH);
    assign w_last_keep = (w_len_rem == 16'd0) ? {KEEP_WIDTH{1'b1}}
                                              : ~({KEEP_WIDTH{1'b1}} << w_len_rem);

    // All error sources of the current beat; length/keep rules differ on the last beat
    assign w_beat_err = (|w_lane_err) || s_axis_tuser
                     || ((beat_idx_q == 16'd0) && (w_seq != w_seq_cmp))
                     || (s_axis_tlast ? ((w_beat_cnt != w_exp_beats) || (s_axis_tkeep != w_last_keep))
                                      : (s_axis_tkeep != {KEEP_WIDTH{1'b1}}));
    assign w_pkt_err  = pkt_err_q || w_beat_err;

    assign in_pkt_d         = w_acc ? !s_axis_tlast : (beat_idx_q != 16'd0);
    assign w_perf_cycle_inc = perf_cycle_q + 1'b1;

    // Control FSM, per-packet tracking, counters and perf window
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            exp_len_q    <= '0;
            exp_seq_q    <= '0;
            pkt_seq_q    <= '0;
            beat_idx_q   <= '0;
            pkt_err_q    <= 1'b0;
            first_q      <= 1'b0;
            recv_q       <= '0;
            err_q        <= '0;
            total_q      <= '0;
            perf_cycle_q <= '0;
            perf_beat_q  <= '0;
            perf_run_q   <= 1'b0;
            perf_full_q  <= 1'b0;
        end else if (clear) begin
            state_q      <= ST_IDLE;
            exp_len_q    <= '0;
            exp_seq_q    <= '0;
            pkt_seq_q    <= '0;
            beat_idx_q   <= '0;
            pkt_err_q    <= 1'b0;
            first_q      <= 1'b0;
            recv_q       <= '0;
            err_q        <= '0;
            total_q      <= '0;
            perf_cycle_q <= '0;
            perf_beat_q  <= '0;
            perf_run_q   <= 1'b0;
            perf_full_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (recv_enable) begin
                        state_q   <= ST_WAIT_FIRST;
                        exp_len_q <= pkt_size;
                    end
                end
                ST_WAIT_FIRST: begin
                    if (w_acc) begin
                        state_q   <= ST_RUN;
                        first_q   <= 1'b1;
                        exp_seq_q <= w_seq;
                    end else if (!recv_enable) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!recv_enable && !in_pkt_d) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (w_acc) begin
                total_q <= sat_inc(total_q);
                if (s_axis_tlast) begin
                    beat_idx_q <= '0;
                    pkt_err_q  <= 1'b0;
                    recv_q     <= sat_inc(recv_q);
                    if (w_pkt_err) err_q <= sat_inc(err_q);
                    exp_seq_q  <= w_seq + 16'd1;
                end else begin
                    beat_idx_q <= (&beat_idx_q) ? beat_idx_q : beat_idx_q + 16'd1;
                    pkt_err_q  <= w_pkt_err;
                    pkt_seq_q  <= w_seq;
                end
            end

            if (!perf_full_q) begin
                if (w_acc) begin
                    perf_beat_q <= sat_inc(perf_beat_q);
                    perf_run_q  <= 1'b1;
                end
                if (perf_run_q) begin
                    perf_cycle_q <= w_perf_cycle_inc;
                    if (w_perf_cycle_inc == PERF_LAST) perf_full_q <= 1'b1;
                end
            end
        end
    end

    assign is_recv_first_pkt     = first_q;
    assign recv_pkt_num          = recv_q;
    assign err_pkt_num           = err_q;
    assign total_beat_count      = total_q;
    assign perf_cycle_count      = perf_cycle_q;
    assign perf_beat_count       = perf_beat_q;
    assign perf_cycle_count_full = perf_full_q;

endmodule
`default_nettype wire

// File: tb/tb_udp_rx_axis_pkt_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_udp_rx_axis_pkt_checker
//  Purpose  : Self-checking bench for udp_rx_axis_pkt_checker. Table of
//             packets with hand-computed error outcomes, plus directed
//             sequences for perf window, enable drop, clear and reset.
//  Options  : RX_CHECKER_BP_EN - also exercises random backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_udp_rx_axis_pkt_checker;

    localparam logic [63:0] ALL  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] K100 = 64'h0000_000F_FFFF_FFFF;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         s_axis_tvalid, s_axis_tready;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic         s_axis_tlast, s_axis_tuser;
    logic         recv_enable, clear;
    logic [15:0]  pkt_size;
`ifdef RX_CHECKER_BP_EN
    logic [7:0]   bp_rate;
`endif
    logic         is_recv_first_pkt;
    logic [31:0]  recv_pkt_num, err_pkt_num, total_beat_count;
    logic [31:0]  perf_cycle_count, perf_beat_count;
    logic         perf_cycle_count_full;

    int vectors     = 0;
    int miscompares = 0;
    int stalls      = 0;

    udp_rx_axis_pkt_checker #(
        .DATA_WIDTH (512),
        .KEEP_WIDTH (64),
        .CNT_WIDTH  (32),
        .PERF_WINDOW(16)
    ) dut (
        .CLK                  (CLK),
        .RST_N                (RST_N),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tready        (s_axis_tready),
        .s_axis_tdata         (s_axis_tdata),
        .s_axis_tkeep         (s_axis_tkeep),
        .s_axis_tlast         (s_axis_tlast),
        .s_axis_tuser         (s_axis_tuser),
        .recv_enable          (recv_enable),
        .clear                (clear),
        .pkt_size             (pkt_size),
`ifdef RX_CHECKER_BP_EN
        .bp_rate              (bp_rate),
`endif
        .is_recv_first_pkt    (is_recv_first_pkt),
        .recv_pkt_num         (recv_pkt_num),
        .err_pkt_num          (err_pkt_num),
        .total_beat_count     (total_beat_count),
        .perf_cycle_count     (perf_cycle_count),
        .perf_beat_count      (perf_beat_count),
        .perf_cycle_count_full(perf_cycle_count_full)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] size;
        logic [15:0] seq;
        int          nbeats;
        logic [63:0] last_keep;
        int          cbeat;   // beat with a corrupted byte, -1 none
        int          cbyte;
        int          ubeat;   // beat with tuser set, -1 none
        int          err;     // expected error increment
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic [15:0] size, input logic [15:0] seq, input int nb,
                        input logic [63:0] lk, input int cbeat, input int cbyte,
                        input int ubeat, input int err);
        vec_t v;
        v.size = size; v.seq = seq; v.nbeats = nb; v.last_keep = lk;
        v.cbeat = cbeat; v.cbyte = cbyte; v.ubeat = ubeat; v.err = err;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one beat, hold until handshake; starts and ends #1 after a posedge
    task automatic send_beat(input logic [15:0] seq, input int b, input logic [63:0] keep,
                             input logic last, input logic user, input int cbyte);
        logic [511:0] d;
        int waited;
        waited = 0;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = {seq, 16'(b)};
        if (cbyte >= 0) d[cbyte*8 +: 8] = d[cbyte*8 +: 8] ^ 8'hFF;
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = keep;
        s_axis_tlast  = last; s_axis_tuser = user;
        @(negedge CLK);
        while (!s_axis_tready && waited < 200) begin
            stalls++;
            waited++;
            @(negedge CLK);
        end
        if (!s_axis_tready) begin
            vectors++;
            miscompares++;
            $display("FAIL beat handshake timeout: tready=%0b, required 1", s_axis_tready);
            s_axis_tvalid = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    endtask

    task automatic send_pkt(input vec_t v);
        for (int b = 0; b < v.nbeats; b++) begin
            send_beat(v.seq, b, (b == v.nbeats - 1) ? v.last_keep : ALL,
                      (b == v.nbeats - 1), (b == v.ubeat), (b == v.cbeat) ? v.cbyte : -1);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge CLK); #1;
        clear = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " tready"},     64'(s_axis_tready), 64'd0);
        chk({tag, " first"},      64'(is_recv_first_pkt), 64'd0);
        chk({tag, " recv"},       64'(recv_pkt_num), 64'd0);
        chk({tag, " err"},        64'(err_pkt_num), 64'd0);
        chk({tag, " total_beat"}, 64'(total_beat_count), 64'd0);
        chk({tag, " perf_cycle"}, 64'(perf_cycle_count), 64'd0);
        chk({tag, " perf_beat"},  64'(perf_beat_count), 64'd0);
        chk({tag, " perf_full"},  64'(perf_cycle_count_full), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned exp_recv, exp_err, exp_beats;
        logic [15:0] cur_size;

        RST_N = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; recv_enable = 1'b0; clear = 1'b0;
        pkt_size = 16'd128;
`ifdef RX_CHECKER_BP_EN
        bp_rate = 8'd0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Packet table: expected error outcome per packet
        addv(128, 16'h0000, 2, ALL, -1, 0, -1, 0);
        addv(128, 16'h0001, 2, ALL, -1, 0, -1, 0);
        addv(128, 16'h0002, 2, ALL, -1, 0, -1, 0);
        addv(128, 16'h0003, 2, ALL, -1, 0, -1, 0);
        addv(100, 16'h000A, 2, K100, -1, 0, -1, 0);          // re-enable resyncs seq
        addv(100, 16'h000B, 2, 64'hFF, -1, 0, -1, 1);        // bad last tkeep
        addv(100, 16'h0004, 2, K100, -1, 0, -1, 1);          // exp 12, resync to 5
        addv(100, 16'h0005, 2, K100, -1, 0, -1, 0);
        addv(100, 16'h0006, 2, K100, -1, 0, -1, 0);
        addv(100, 16'h0008, 2, K100, -1, 0, -1, 1);          // gap
        addv(100, 16'h0009, 2, K100, -1, 0, -1, 0);
        addv(100, 16'h000A, 2, K100, -1, 0, -1, 0);
        addv(100, 16'hFFFE, 2, K100, -1, 0, -1, 1);          // exp 11
        addv(100, 16'hFFFF, 2, K100, -1, 0, -1, 0);
        addv(100, 16'h0000, 2, K100, -1, 0, -1, 0);          // wrap
        addv(100, 16'h0001, 2, K100, -1, 0, -1, 0);
        addv(100, 16'h0002, 2, K100, 1, 17, -1, 1);          // corrupt byte 17 of beat 1
        addv(100, 16'h0003, 2, K100, -1, 0, 0, 1);           // tuser
        addv(100, 16'h0004, 2, K100, -1, 0, -1, 0);
        addv(100, 16'h0005, 1, K100, -1, 0, -1, 1);          // too short
        addv(100, 16'h0006, 3, K100, -1, 0, -1, 1);          // too long
        addv(100, 16'h0007, 2, K100, -1, 0, -1, 0);
        addv(64,  16'h0064, 1, ALL, -1, 0, -1, 0);           // exact multiple of 64
        addv(64,  16'h0065, 1, 64'h0000_0000_FFFF_FFFF, -1, 0, -1, 1);

        exp_recv = 0; exp_err = 0; exp_beats = 0; cur_size = 16'd0;
        foreach (vq[i]) begin
            if (vq[i].size != cur_size) begin
                recv_enable = 1'b0;
                repeat (3) @(posedge CLK);
                #1;
                chk($sformatf("row%0d idle tready", i), 64'(s_axis_tready), 64'd0);
                pkt_size = vq[i].size;
                cur_size = vq[i].size;
                recv_enable = 1'b1;
                @(posedge CLK); #1;
            end
            send_pkt(vq[i]);
            exp_recv  += 1;
            exp_err   += vq[i].err;
            exp_beats += vq[i].nbeats;
            @(negedge CLK);
            chk($sformatf("row%0d recv", i), 64'(recv_pkt_num), 64'(exp_recv));
            chk($sformatf("row%0d err", i), 64'(err_pkt_num), 64'(exp_err));
            chk($sformatf("row%0d total_beat", i), 64'(total_beat_count), 64'(exp_beats));
            if (i == 0) chk("first pkt flag", 64'(is_recv_first_pkt), 64'd1);
            @(posedge CLK); #1;
        end

        // Perf window: 20 back-to-back single-beat packets after clear
        pulse_clear();
        chk_all_zero("clear1");
        @(posedge CLK); #1;
        for (int k = 0; k < 20; k++) send_beat(16'(k), 0, ALL, 1'b1, 1'b0, -1);
        @(negedge CLK);
        chk("perf full", 64'(perf_cycle_count_full), 64'd1);
        chk("perf cycle", 64'(perf_cycle_count), 64'd15);
        chk("perf beat", 64'(perf_beat_count), 64'd16);
        chk("perf total_beat", 64'(total_beat_count), 64'd20);
        chk("perf recv", 64'(recv_pkt_num), 64'd20);
        chk("perf err", 64'(err_pkt_num), 64'd0);
        @(posedge CLK); #1;

        // Drop recv_enable mid-packet: packet completes, then ready falls
        recv_enable = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        pkt_size = 16'd128;
        recv_enable = 1'b1;
        @(posedge CLK); #1;
        send_beat(16'h0032, 0, ALL, 1'b0, 1'b0, -1);
        recv_enable = 1'b0;
        send_beat(16'h0032, 1, ALL, 1'b1, 1'b0, -1);
        @(negedge CLK);
        chk("middrop recv", 64'(recv_pkt_num), 64'd21);
        chk("middrop err", 64'(err_pkt_num), 64'd0);
        chk("middrop total_beat", 64'(total_beat_count), 64'd22);
        chk("middrop tready", 64'(s_axis_tready), 64'd0);
        chk("middrop perf frozen cycle", 64'(perf_cycle_count), 64'd15);
        chk("middrop perf frozen beat", 64'(perf_beat_count), 64'd16);
        @(posedge CLK); #1;

        pulse_clear();
        chk_all_zero("clear2");

        // Clear and an accepted beat in the same cycle: clear wins
        recv_enable = 1'b1;
        @(posedge CLK); #1;
        s_axis_tvalid = 1'b1; s_axis_tdata = '0; s_axis_tkeep = ALL;
        s_axis_tlast = 1'b1; clear = 1'b1;
        @(negedge CLK);
        chk("clrbeat tready", 64'(s_axis_tready), 64'd1);
        @(posedge CLK); #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; clear = 1'b0;
        @(negedge CLK);
        chk("clrbeat total_beat", 64'(total_beat_count), 64'd0);
        chk("clrbeat recv", 64'(recv_pkt_num), 64'd0);
        chk("clrbeat first", 64'(is_recv_first_pkt), 64'd0);
        chk("clrbeat perf_beat", 64'(perf_beat_count), 64'd0);
        @(posedge CLK); #1;

        // Asynchronous reset mid-packet: partial packet never counted
        @(posedge CLK); #1;
        send_beat(16'h0007, 0, ALL, 1'b0, 1'b0, -1);
        #2 RST_N = 1'b0;
        #1;
        chk("rstmid total_beat", 64'(total_beat_count), 64'd0);
        chk("rstmid tready", 64'(s_axis_tready), 64'd0);
        #2 RST_N = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        send_beat(16'h0009, 0, ALL, 1'b0, 1'b0, -1);
        send_beat(16'h0009, 1, ALL, 1'b1, 1'b0, -1);
        @(negedge CLK);
        chk("rstmid recv", 64'(recv_pkt_num), 64'd1);
        chk("rstmid err", 64'(err_pkt_num), 64'd0);
        chk("rstmid total_beat after", 64'(total_beat_count), 64'd2);
        @(posedge CLK); #1;

`ifdef RX_CHECKER_BP_EN
        // Random backpressure: 100 good packets still check clean
        pulse_clear();
        bp_rate = 8'd128;
        stalls = 0;
        @(posedge CLK); #1;
        for (int p = 0; p < 100; p++) begin
            send_beat(16'(p), 0, ALL, 1'b0, 1'b0, -1);
            send_beat(16'(p), 1, ALL, 1'b1, 1'b0, -1);
        end
        @(negedge CLK);
        chk("bp recv", 64'(recv_pkt_num), 64'd100);
        chk("bp err", 64'(err_pkt_num), 64'd0);
        chk("bp stalls seen", 64'(stalls != 0), 64'd1);
        bp_rate = 8'd0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
